conv_mem_host: RTL and testbench
================================

// Module: conv_mem_host
// PURPOSE
//  Memory-side responder for the convolution/max-pool engine: owns the 64x64 image ROM,
//  the layer-0 (conv) RAM and the layer-1 (max-pool) RAM. Raises ready, then serves the
//  engine's reads and writes. Detects completion and exposes a dump port for checking.
//  Sits between the system loader/checker and the engine.
// PARAMETERS
//  AW        12    address width of iaddr/caddr_wr/caddr_rd
//  DW        20    data width (Q4.16)
//  L1_WORDS  1024  layer-1 depth; addresses >= L1_WORDS are illegal
// PORTS
//  clk       in   1   clock
//  reset     in   1   synchronous active-high reset
//  ld_valid  in   1   image load strobe
//  ld_addr   in   AW  image load address
//  ld_data   in   DW  image load data
//  ld_last   in   1   marks the final load beat
//  restart   in   1   return to LOAD from DONE
//  ready     out  1   image available to engine
//  busy      in   1   engine busy
//  iaddr     in   AW  image read address
//  idata     out  DW  image read data
//  csel      in   3   001 = L0, 011 = L1; other values select no bank
//  cwr       in   1   write enable
//  caddr_wr  in   AW  write address
//  cdata_wr  in   DW  write data
//  crd       in   1   read enable
//  caddr_rd  in   AW  read address
//  cdata_rd  out  DW  read data
//  done      out  1   engine finished
//  l0_wr_cnt out  13  L0 writes accepted
//  l1_wr_cnt out  11  L1 writes accepted
//  err       out  2   sticky: [0] bad csel on cwr/crd, [1] L1 address out of range
//  dmp_sel   in   1   0 = L0, 1 = L1
//  dmp_addr  in   AW  dump address
//  dmp_data  out  DW  dump data, registered
// BEHAVIOUR
//  - Reset (sync, all regs): state LOAD; ready=0, done=0, counters=0, err=0, dmp_data=0.
//    Memory contents are not cleared. Reset mid-run aborts immediately, with no further writes.
//  - FSM LOAD -> READY -> RUN -> DONE -> LOAD:
//    - LOAD: ld_valid writes img[ld_addr] at the edge. ld_valid & ld_last -> READY.
//      ld_valid is ignored in every other state.
//    - READY: ready=1 (registered). busy==1 -> RUN, and ready drops that same edge.
//    - RUN: ready=0. Falling edge of busy (busy_q=1 & busy=0) -> DONE.
//    - DONE: done=1 (held). restart -> LOAD, clearing done, counters and err.
//  - Image read: idata = img[iaddr], combinational (async read), in every state.
//    The engine samples it one cycle after iaddr changes.
//  - Writes: accepted only in RUN.
//    - cwr & csel==001: L0[caddr_wr] <= cdata_wr; l0_wr_cnt++.
//    - cwr & csel==011 & caddr_wr<L1_WORDS: L1[caddr_wr] <= cdata_wr; l1_wr_cnt++.
//    - cwr & csel==011 & caddr_wr>=L1_WORDS: write dropped; err[1]=1.
//    - cwr or crd with any other csel: err[0]=1, no access.
//    - cwr outside RUN: ignored, no error.
//  - Counters saturate: l0 at 4096, l1 at 1024.
//  - Reads: cdata_rd = crd ? (csel==001 ? L0[caddr_rd] : csel==011 ? L1[caddr_rd[9:0]] : 0) : 0.
//    Combinational.
//  - Same-address write and read in one cycle: read returns the old value; new data is visible next cycle.
//  - Dump: dmp_data <= dmp_sel ? L1[dmp_addr[9:0]] : L0[dmp_addr], every cycle, 1-cycle latency.
//    Valid in any state.
// TESTING
//  1. Load 4096 words with img[a]=a, ld_last on a=4095 -> ready=1 next cycle; ld_valid afterwards does not modify img.
//  2. In READY, raise busy -> ready=0 the next cycle; iaddr=0x041 -> idata=0x00041 in the same cycle.
//  3. RUN, cwr csel=001 caddr_wr=0x123 data=0x0ABCD, then crd on 0x123 -> cdata_rd=0x0ABCD; l0_wr_cnt=1.
//     The same-cycle read of 0x123 still returns the old value.
//  4. RUN, cwr csel=011 caddr_wr=0x400 -> err[1]=1, l1_wr_cnt unchanged. cwr with csel=010 -> err[0]=1.
//  5. Drop busy -> done=1 next cycle; dmp_sel=1 dmp_addr=5 -> dmp_data=L1[5] one cycle later.
//     restart -> LOAD, with done=0 and counters=0.
//  6. Assert reset during RUN with cwr held high -> no write lands; ready, done and err are 0; L0 data written before the reset is retained.

Source files
------------

// File: rtl/conv_mem_host.sv
// Memory-side responder for the conv/max-pool engine: image ROM, L0 and L1 RAMs,
// load/ready/run/done sequencing, write accounting, sticky errors and a dump port.
module conv_mem_host #(
  parameter int AW       = 12,
  parameter int DW       = 20,
  parameter int L1_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          restart,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic [2:0]    csel,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  output logic          done,
  output logic [AW:0]   l0_wr_cnt,
  output logic [$clog2(L1_WORDS):0] l1_wr_cnt,
  output logic [1:0]    err,
  input  logic          dmp_sel,
  input  logic [AW-1:0] dmp_addr,
  output logic [DW-1:0] dmp_data
);
  localparam int L1_AW    = $clog2(L1_WORDS);
  localparam int L0_WORDS = 1 << AW;

  typedef enum logic [1:0] {LOAD, READY, RUN, DONE} state_t;
  state_t state;

  logic [DW-1:0] img [L0_WORDS];
  logic [DW-1:0] l0  [L0_WORDS];
  logic [DW-1:0] l1  [L1_WORDS];

  logic busy_q, sel_l0, sel_l1, l1_ok, in_run, l0_we, l1_we, bad_sel, l1_oob;

  always_comb begin
    sel_l0  = (csel == 3'b001);
    sel_l1  = (csel == 3'b011);
    l1_ok   = (caddr_wr < AW'(L1_WORDS));
    in_run  = (state == RUN);
    l0_we   = in_run & cwr & sel_l0;
    l1_we   = in_run & cwr & sel_l1 & l1_ok;
    l1_oob  = in_run & cwr & sel_l1 & ~l1_ok;
    bad_sel = in_run & (cwr | crd) & ~sel_l0 & ~sel_l1;
  end

  // Memories are never cleared; reset only blocks writes in that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD && ld_valid) img[ld_addr] <= ld_data;
      if (l0_we) l0[caddr_wr] <= cdata_wr;
      if (l1_we) l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
    end
  end

  always_comb begin
    idata    = img[iaddr];
    cdata_rd = '0;
    if (crd) begin
      if (sel_l0)      cdata_rd = l0[caddr_rd];
      else if (sel_l1) cdata_rd = l1[caddr_rd[L1_AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      ready     <= 1'b0;
      done      <= 1'b0;
      busy_q    <= 1'b0;
      l0_wr_cnt <= '0;
      l1_wr_cnt <= '0;
      err       <= '0;
      dmp_data  <= '0;
    end else begin
      busy_q   <= busy;
      dmp_data <= dmp_sel ? l1[dmp_addr[L1_AW-1:0]] : l0[dmp_addr];
      case (state)
        LOAD: if (ld_valid && ld_last) begin
          state <= READY;
          ready <= 1'b1;
        end
        READY: if (busy) begin
          state <= RUN;
          ready <= 1'b0;
        end
        RUN: begin
          if (l0_we && l0_wr_cnt != (AW+1)'(L0_WORDS)) l0_wr_cnt <= l0_wr_cnt + 1'b1;
          if (l1_we && l1_wr_cnt != (L1_AW+1)'(L1_WORDS)) l1_wr_cnt <= l1_wr_cnt + 1'b1;
          if (bad_sel) err[0] <= 1'b1;
          if (l1_oob)  err[1] <= 1'b1;
          if (busy_q && !busy) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: if (restart) begin
          state     <= LOAD;
          done      <= 1'b0;
          l0_wr_cnt <= '0;
          l1_wr_cnt <= '0;
          err       <= '0;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: load, run, writes/reads, errors, dump, restart, reset abort.
module tb_conv_mem_host;
  logic        clk = 0, reset = 1, ld_valid = 0, ld_last = 0, restart = 0, busy = 0;
  logic [11:0] ld_addr = 0, iaddr = 0, caddr_wr = 0, caddr_rd = 0, dmp_addr = 0;
  logic [19:0] ld_data = 0, cdata_wr = 0;
  logic [2:0]  csel = 0;
  logic        cwr = 0, crd = 0, dmp_sel = 0;
  logic        ready, done;
  logic [19:0] idata, cdata_rd, dmp_data;
  logic [12:0] l0_wr_cnt;
  logic [10:0] l1_wr_cnt;
  logic [1:0]  err;
  int errors = 0, checks = 0;

  conv_mem_host dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .restart(restart), .ready(ready), .busy(busy), .iaddr(iaddr),
    .idata(idata), .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .done(done),
    .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt), .err(err), .dmp_sel(dmp_sel),
    .dmp_addr(dmp_addr), .dmp_data(dmp_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle 1 ns later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [11:0] a, input logic [19:0] d);
    csel = s; caddr_wr = a; cdata_wr = d; cwr = 1; step(); cwr = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_l0cnt", l0_wr_cnt, 0);
    chk("rst_l1cnt", l1_wr_cnt, 0);
    chk("rst_dmp", dmp_data, 0);
    reset = 0;

    // 1: image load
    for (int a = 0; a < 4096; a++) begin
      ld_valid = 1; ld_addr = 12'(a); ld_data = 20'(a); ld_last = (a == 4095);
      step();
    end
    chk("load_ready", ready, 1);
    ld_addr = 12'h041; ld_data = 20'hFFFFF; ld_last = 0; step(); ld_valid = 0;
    iaddr = 12'h041; #1;
    chk("idata_041", idata, 20'h00041);
    iaddr = 12'hFFF; #1;
    chk("idata_fff", idata, 20'h00FFF);

    // 2: start run
    busy = 1; step();
    chk("run_ready", ready, 0);

    // 3: L0 / L1 writes and reads
    wr(3'b001, 12'h123, 20'h11111);
    csel = 3'b001; caddr_wr = 12'h123; cdata_wr = 20'h0ABCD; cwr = 1;
    crd = 1; caddr_rd = 12'h123; #1;
    chk("rdw_old", cdata_rd, 20'h11111);
    step(); cwr = 0; #1;
    chk("rd_new", cdata_rd, 20'h0ABCD);
    chk("l0cnt", l0_wr_cnt, 2);
    wr(3'b011, 12'h005, 20'h55555);
    wr(3'b011, 12'h3FF, 20'h3FF00);
    chk("l1cnt", l1_wr_cnt, 2);
    csel = 3'b011; caddr_rd = 12'h005; #1;
    chk("rd_l1_5", cdata_rd, 20'h55555);
    caddr_rd = 12'h405; #1;
    chk("rd_l1_wrap", cdata_rd, 20'h55555);
    caddr_rd = 12'h3FF; #1;
    chk("rd_l1_3ff", cdata_rd, 20'h3FF00);
    crd = 0; #1;
    chk("rd_noen", cdata_rd, 0);
    chk("err_clean", err, 0);

    // 4: errors
    wr(3'b011, 12'h400, 20'h77777);
    chk("err_oob", err, 2'b10);
    chk("l1cnt_oob", l1_wr_cnt, 2);
    wr(3'b010, 12'h123, 20'h00000);
    chk("err_sel", err, 2'b11);
    chk("l0cnt_badsel", l0_wr_cnt, 2);

    // 5: done, dump, restart
    busy = 0; step();
    chk("done", done, 1);
    dmp_sel = 1; dmp_addr = 12'h005; step();
    chk("dmp_l1_5", dmp_data, 20'h55555);
    wr(3'b001, 12'h123, 20'h00000);
    dmp_sel = 0; dmp_addr = 12'h123; step();
    chk("dmp_l0_123", dmp_data, 20'h0ABCD);
    chk("l0cnt_done", l0_wr_cnt, 2);
    restart = 1; step(); restart = 0;
    chk("rs_done", done, 0);
    chk("rs_l0cnt", l0_wr_cnt, 0);
    chk("rs_l1cnt", l1_wr_cnt, 0);
    chk("rs_err", err, 0);
    chk("rs_ready", ready, 0);

    // Second run: L1 counter saturation, then reset abort
    ld_valid = 1; ld_last = 1; ld_addr = 0; ld_data = 0; step(); ld_valid = 0; ld_last = 0;
    chk("ready2", ready, 1);
    busy = 1; step();
    for (int a = 0; a < 1025; a++) wr(3'b011, 12'(a % 1024), 20'(a));
    chk("l1cnt_sat", l1_wr_cnt, 11'd1024);
    wr(3'b001, 12'h200, 20'h22222);
    wr(3'b111, 12'h000, 20'h0);
    chk("err_pre_rst", err, 2'b01);

    // 6: reset during RUN with a write held
    csel = 3'b001; caddr_wr = 12'h200; cdata_wr = 20'h99999; cwr = 1; reset = 1;
    step(); step();
    chk("rr_ready", ready, 0);
    chk("rr_done", done, 0);
    chk("rr_err", err, 0);
    chk("rr_l1cnt", l1_wr_cnt, 0);
    cwr = 0; busy = 0; reset = 0;
    dmp_sel = 0; dmp_addr = 12'h200; step();
    chk("rr_retain", dmp_data, 20'h22222);
    ld_valid = 1; ld_last = 1; step(); ld_valid = 0; ld_last = 0;
    chk("rr_load", ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
